input_conditioner: RTL and testbench

//  Front-end conditioner for the asynchronous field inputs of the experiment sequencer.

---
 rtl/input_conditioner.sv | 119 +++++++++++
 tb/tb_input_conditioner.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// input_conditioner
//   Front-end conditioner for the asynchronous field inputs of the experiment
//   sequencer (start button, fast-gate opto, phase, wire sensor, detector-ready).
//   Each channel is synchronized through two flops and then debounced. A level
//   change is accepted only after it has been held for DEBOUNCE_CYCLES clocks.
//   An accepted change produces a single-clock rise or fall strobe. A change
//   that reverts before acceptance is counted as a bounce, in a saturating
//   per-channel counter.
//
// Ports
//   clock         system clock (200 MHz)
//   reset         asynchronous, active-high; returns every register to its idle value
//   sig_in        raw asynchronous inputs, one bit per channel
//   bounce_clear  synchronous clear of all bounce counters
//   sig_level     debounced level per channel
//   sig_rise      1-clock strobe when sig_level goes 0->1
//   sig_fall      1-clock strobe when sig_level goes 1->0
//   bounce_count  rejected transitions; channel k occupies [k*CNT_W +: CNT_W]
module input_conditioner #(
  parameter int              N_CH            = 5,
  parameter int              DEBOUNCE_CYCLES = 40,
  parameter int              CNT_W           = 8,
  parameter logic [N_CH-1:0] INIT_LEVEL      = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sig_in,
  input  logic                    bounce_clear,
  output logic [N_CH-1:0]         sig_level,
  output logic [N_CH-1:0]         sig_rise,
  output logic [N_CH-1:0]         sig_fall,
  output logic [N_CH*CNT_W-1:0]   bounce_count
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_CHECK  = 1'b1;

  logic [N_CH-1:0] sync_p0;
  logic [N_CH-1:0] sync_p1;
  logic [N_CH-1:0] state;
  logic [CW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] bounce_inc;

  // Clear wins over the held value, but an increment landing in the same
  // clock as the clear is kept so the event is not lost.
  function automatic logic [CNT_W-1:0] bounce_next(input logic [CNT_W-1:0] cur,
                                                   input logic             inc,
                                                   input logic             clr);
    if (clr) begin
      return inc ? CNT_W'(1) : '0;
    end
    if (inc && (cur != {CNT_W{1'b1}})) begin
      return cur + CNT_W'(1);
    end
    return cur;
  endfunction

  // A bounce is a return to the accepted level while a change is being qualified.
  always_comb begin
    bounce_inc = '0;
    for (int k = 0; k < N_CH; k++) begin
      bounce_inc[k] = (state[k] == ST_CHECK) && (sync_p1[k] == sig_level[k]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0      <= INIT_LEVEL;
      sync_p1      <= INIT_LEVEL;
      sig_level    <= INIT_LEVEL;
      sig_rise     <= '0;
      sig_fall     <= '0;
      state        <= '0;
      bounce_count <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      // stage p0 -> p1: two-flop synchronizer; only sync_p1 feeds the debouncer
      sync_p0 <= sig_in;
      sync_p1 <= sync_p0;

      // debounce stage: per-channel STABLE/CHECK machine on sync_p1
      for (int k = 0; k < N_CH; k++) begin
        sig_rise[k] <= 1'b0;
        sig_fall[k] <= 1'b0;
        if (state[k] == ST_STABLE) begin
          if (sync_p1[k] != sig_level[k]) begin
            state[k] <= ST_CHECK;
            cnt[k]   <= CNT_ONE;
          end else begin
            cnt[k]   <= '0;
          end
        end else begin
          if (sync_p1[k] == sig_level[k]) begin
            state[k] <= ST_STABLE;
            cnt[k]   <= '0;
          end else if (cnt[k] == CNT_MAX) begin
            sig_level[k] <= sync_p1[k];
            sig_rise[k]  <= sync_p1[k];
            sig_fall[k]  <= ~sync_p1[k];
            state[k]     <= ST_STABLE;
            cnt[k]       <= '0;
          end else begin
            cnt[k] <= cnt[k] + CNT_ONE;
          end
        end
        bounce_count[k*CNT_W +: CNT_W] <=
          bounce_next(bounce_count[k*CNT_W +: CNT_W], bounce_inc[k], bounce_clear);
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
`timescale 1ns/100ps
module tb_input_conditioner;

  localparam int N_CH  = 5;
  localparam int DC    = 40;
  localparam int CNT_W = 8;
  localparam int BC_MAX = (1 << CNT_W) - 1;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       sig_in = '0;
  logic                  bounce_clear = 1'b0;
  logic [N_CH-1:0]       sig_level;
  logic [N_CH-1:0]       sig_rise;
  logic [N_CH-1:0]       sig_fall;
  logic [N_CH*CNT_W-1:0] bounce_count;

  int n_tests = 0;
  int n_fail  = 0;

  input_conditioner #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W), .INIT_LEVEL('0)
  ) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .bounce_clear(bounce_clear),
    .sig_level(sig_level), .sig_rise(sig_rise), .sig_fall(sig_fall),
    .bounce_count(bounce_count)
  );

  always #2.5 clock = ~clock;

  // Reference model: a change is accepted once the synchronized sample has
  // differed from the accepted level for DC+1 consecutive samples; a run of
  // differing samples that ends early is one bounce.
  logic [N_CH-1:0] m_p0 = '0, m_p1 = '0, m_s = '0;
  logic [N_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0;
  int              m_run [N_CH];
  int              m_bc  [N_CH];
  logic            m_inc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_p0 = '0; m_p1 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      for (int k = 0; k < N_CH; k++) begin m_run[k] = 0; m_bc[k] = 0; end
    end else begin
      m_s  = m_p1;
      m_p1 = m_p0;
      m_p0 = sig_in;
      for (int k = 0; k < N_CH; k++) begin
        m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_inc = 1'b0;
        if (m_s[k] != m_level[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] > DC) begin
            m_level[k] = m_s[k];
            m_rise[k]  = m_s[k];
            m_fall[k]  = ~m_s[k];
            m_run[k]   = 0;
          end
        end else begin
          m_inc    = (m_run[k] > 0);
          m_run[k] = 0;
        end
        if (bounce_clear)                    m_bc[k] = m_inc ? 1 : 0;
        else if (m_inc && m_bc[k] < BC_MAX)  m_bc[k] = m_bc[k] + 1;
      end
    end
  end

  function automatic logic [N_CH*CNT_W-1:0] model_bc_packed();
    logic [N_CH*CNT_W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) r[k*CNT_W +: CNT_W] = CNT_W'(m_bc[k]);
    return r;
  endfunction

  // Strobe tallies, only written here; scenarios take differences.
  int rise_cnt [N_CH];
  int fall_cnt [N_CH];
  initial for (int k = 0; k < N_CH; k++) begin rise_cnt[k] = 0; fall_cnt[k] = 0; end
  always @(negedge clock) begin
    for (int k = 0; k < N_CH; k++) begin
      if (sig_rise[k] === 1'b1) rise_cnt[k] = rise_cnt[k] + 1;
      if (sig_fall[k] === 1'b1) fall_cnt[k] = fall_cnt[k] + 1;
    end
  end

  task automatic test_reset();
    sig_in = 5'b10101;
    repeat (60) @(negedge clock);
    #1 sig_in[1] = 1'b1;
    repeat (5) @(negedge clock);
    #1 sig_in[1] = 1'b0;
    repeat (10) @(negedge clock);
    n_tests++;
    if (sig_level !== 5'b10101) begin
      n_fail++; $display("FAIL reset_pre_level: got %b expected %b", sig_level, 5'b10101);
    end
    n_tests++;
    if (bounce_count[1*CNT_W +: CNT_W] !== 8'd1) begin
      n_fail++; $display("FAIL reset_pre_bounce1: got %0d expected 1", bounce_count[1*CNT_W +: CNT_W]);
    end
    @(posedge clock);
    #1.5 reset = 1'b1;
    sig_in = '0;
    #0.5;
    n_tests++;
    if (sig_level !== '0) begin
      n_fail++; $display("FAIL reset_async_level: got %b expected 0", sig_level);
    end
    n_tests++;
    if (sig_rise !== '0 || sig_fall !== '0) begin
      n_fail++; $display("FAIL reset_async_strobes: got rise %b fall %b expected 0", sig_rise, sig_fall);
    end
    n_tests++;
    if (bounce_count !== '0) begin
      n_fail++; $display("FAIL reset_async_bounce: got %h expected 0", bounce_count);
    end
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    repeat (50) @(negedge clock);
    n_tests++;
    if (sig_level !== '0 || bounce_count !== '0) begin
      n_fail++; $display("FAIL reset_after_release: got level %b bounce %h expected 0/0", sig_level, bounce_count);
    end
  endtask

  task automatic test_clean_edge();
    int n, r0, f0;
    r0 = rise_cnt[3]; f0 = fall_cnt[3];
    @(negedge clock);
    #1 sig_in[3] = 1'b1;
    n = 0;
    while (sig_level[3] !== 1'b1 && n < 100) begin
      @(posedge clock); #1 n++;
    end
    n_tests++;
    if (n < 42 || n > 43) begin
      n_fail++; $display("FAIL clean_latency: got %0d clocks expected 42..43", n);
    end
    repeat (200) @(negedge clock);
    n_tests++;
    if (rise_cnt[3] - r0 !== 1 || fall_cnt[3] - f0 !== 0) begin
      n_fail++; $display("FAIL clean_strobes: got rise %0d fall %0d expected 1/0", rise_cnt[3] - r0, fall_cnt[3] - f0);
    end
    n_tests++;
    if (sig_level[3] !== 1'b1 || bounce_count[3*CNT_W +: CNT_W] !== 8'd0) begin
      n_fail++; $display("FAIL clean_state: got level %b bounce %0d expected 1/0", sig_level[3], bounce_count[3*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_glitch();
    int r0, f0;
    r0 = rise_cnt[1]; f0 = fall_cnt[1];
    @(negedge clock);
    #1 sig_in[1] = 1'b1;
    repeat (20) @(negedge clock);
    #1 sig_in[1] = 1'b0;
    repeat (60) @(negedge clock);
    n_tests++;
    if (sig_level[1] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_level: got %b expected 0", sig_level[1]);
    end
    n_tests++;
    if (bounce_count[1*CNT_W +: CNT_W] !== 8'd1) begin
      n_fail++; $display("FAIL glitch_bounce: got %0d expected 1", bounce_count[1*CNT_W +: CNT_W]);
    end
    n_tests++;
    if (rise_cnt[1] - r0 !== 0 || fall_cnt[1] - f0 !== 0) begin
      n_fail++; $display("FAIL glitch_strobes: got rise %0d fall %0d expected 0/0", rise_cnt[1] - r0, fall_cnt[1] - f0);
    end
  endtask

  task automatic test_bouncy_wire();
    int r0, f0, bc;
    @(negedge clock);
    #1 sig_in[3] = 1'b0;
    repeat (60) @(negedge clock);
    #1 bounce_clear = 1'b1;
    @(negedge clock);
    #1 bounce_clear = 1'b0;
    r0 = rise_cnt[3]; f0 = fall_cnt[3];
    for (int i = 0; i < 10; i++) begin
      sig_in[3] = ~sig_in[3];
      #($urandom_range(100, 10) * 1.0);
    end
    sig_in[3] = 1'b1;
    repeat (200) @(negedge clock);
    bc = int'(bounce_count[3*CNT_W +: CNT_W]);
    n_tests++;
    if (rise_cnt[3] - r0 !== 1 || fall_cnt[3] - f0 !== 0) begin
      n_fail++; $display("FAIL bouncy_strobes: got rise %0d fall %0d expected 1/0", rise_cnt[3] - r0, fall_cnt[3] - f0);
    end
    n_tests++;
    if (bc < 1 || bc > 5) begin
      n_fail++; $display("FAIL bouncy_range: got %0d expected 1..5", bc);
    end
    n_tests++;
    if (bc !== m_bc[3]) begin
      n_fail++; $display("FAIL bouncy_model: got %0d expected %0d", bc, m_bc[3]);
    end
  endtask

  task automatic test_reset_mid_check();
    int n, r0;
    @(negedge clock);
    #1 sig_in = '0;
    repeat (60) @(negedge clock);
    r0 = rise_cnt[2];
    #1 sig_in[2] = 1'b1;
    repeat (12) @(posedge clock);
    #1 reset = 1'b1;
    n_tests++;
    if (rise_cnt[2] - r0 !== 0 || sig_level[2] !== 1'b0) begin
      n_fail++; $display("FAIL midcheck_pre: got rise %0d level %b expected 0/0", rise_cnt[2] - r0, sig_level[2]);
    end
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    n = 0;
    while (sig_rise[2] !== 1'b1 && n < 100) begin
      @(posedge clock); #1 n++;
    end
    n_tests++;
    if (n < 42 || n > 43) begin
      n_fail++; $display("FAIL midcheck_latency: got %0d clocks expected 42..43", n);
    end
    repeat (20) @(negedge clock);
    n_tests++;
    if (rise_cnt[2] - r0 !== 1 || sig_level[2] !== 1'b1) begin
      n_fail++; $display("FAIL midcheck_post: got rise %0d level %b expected 1/1", rise_cnt[2] - r0, sig_level[2]);
    end
  endtask

  task automatic test_saturation_clear();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1 sig_in[0] = 1'b1;
      repeat (4) @(negedge clock);
      #1 sig_in[0] = 1'b0;
      repeat (5) @(negedge clock);
    end
    repeat (5) @(negedge clock);
    n_tests++;
    if (bounce_count[0 +: CNT_W] !== 8'd255) begin
      n_fail++; $display("FAIL sat_value: got %0d expected 255", bounce_count[0 +: CNT_W]);
    end
    // next glitch: its increment lands at the third edge after the falling drive
    #1 sig_in[0] = 1'b1;
    repeat (4) @(negedge clock);
    #1 sig_in[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 bounce_clear = 1'b1;
    @(negedge clock);
    #1 bounce_clear = 1'b0;
    n_tests++;
    if (bounce_count[0 +: CNT_W] !== 8'd1) begin
      n_fail++; $display("FAIL clear_with_inc: got %0d expected 1", bounce_count[0 +: CNT_W]);
    end
    repeat (5) @(negedge clock);
    #1 bounce_clear = 1'b1;
    @(negedge clock);
    #1 bounce_clear = 1'b0;
    n_tests++;
    if (bounce_count[0 +: CNT_W] !== 8'd0) begin
      n_fail++; $display("FAIL clear_alone: got %0d expected 0", bounce_count[0 +: CNT_W]);
    end
  endtask

  task automatic test_random();
    int hold [N_CH];
    logic [N_CH-1:0] prev_strobe;
    for (int k = 0; k < N_CH; k++) hold[k] = 1;
    prev_strobe = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      n_tests++;
      if (sig_level !== m_level || sig_rise !== m_rise || sig_fall !== m_fall ||
          bounce_count !== model_bc_packed()) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got lvl %b r %b f %b bc %h expected lvl %b r %b f %b bc %h",
                 c, sig_level, sig_rise, sig_fall, bounce_count,
                 m_level, m_rise, m_fall, model_bc_packed());
      end
      n_tests++;
      if ((sig_rise & sig_fall) !== '0 || ((sig_rise | sig_fall) & prev_strobe) !== '0) begin
        n_fail++; $display("FAIL random_strobe_shape cyc %0d: got rise %b fall %b prev %b expected exclusive, non-consecutive",
                           c, sig_rise, sig_fall, prev_strobe);
      end
      prev_strobe = sig_rise | sig_fall;
      #1;
      for (int k = 0; k < N_CH; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          sig_in[k] = ~sig_in[k];
          hold[k]   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(80, 42)) : int'($urandom_range(45, 1));
        end
      end
      bounce_clear = ($urandom_range(60, 0) == 0);
    end
    bounce_clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bouncy_wire();
    test_reset_mid_check();
    test_saturation_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
